lsu_mem_master: RTL
===================

# lsu_mem_master

Load/store initiator between the core's execute stage and the byte-addressed data memory. It takes one load or store request at a time and turns it into word-aligned memory transactions with byte enables. Accesses that cross a word boundary are split into two beats. Returned bytes are merged and sign- or zero-extended, and the block returns one response per request. It is the requesting end of the data-memory interface; the memory side is a synchronous word RAM with a base-address window.

## Interface
- `BASE_ADDR`, default `32'h8000_2000`: first byte address of the data-memory window.
- `MEM_BYTES`, default `16384`: window size in bytes; must be a power of two and a multiple of 4.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: absolute byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_fn3` in 3: access type, using the `FN3_*` macros from `definitions.svh`.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: access fault; qualified by `rsp_valid`.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: write strobe; qualified by `mem_en`.
- `mem_addr` out 32: absolute, word-aligned address (bits [1:0] = 0).
- `mem_be` out 4: byte enables, bit i = byte lane i.
- `mem_wdata` out 32: lane-shifted store data.
- `mem_rdata` in 32: read word, valid the cycle after a read beat.

## Operation
**States:** IDLE, BEAT0, BEAT1, CAPT, RESP.

**Accept**
- A request is accepted when `req_valid && req_ready`.
- On accept, latch we, addr, wdata and fn3, and compute `size` (1/2/4 bytes), `off = addr[1:0]`, and `split = (off + size > 4)`.

**Legal encodings**
- Loads: LB, LH, LW, LBU, LHU.
- Stores: SB, SH, SW (fn3 000/001/010).
- Any other encoding is a fault.

**Range check**
- Fault if `addr < BASE_ADDR` or `addr + size - 1 >= BASE_ADDR + MEM_BYTES`.
- A faulting request goes IDLE → RESP with `rsp_fault = 1`, `rsp_rdata = 0`, and no memory beat.

**State transitions**
- IDLE → BEAT0 on an accepted legal request.
- BEAT0 drives `mem_en = 1` at `addr & ~3`, with `mem_be = lane_mask << off` truncated to 4 bits.
  - If split → BEAT1.
  - Else, if load → CAPT.
  - Else (store) → RESP.
- BEAT1 drives `mem_en = 1` at `(addr & ~3) + 4`, with `mem_be` = the remaining low lanes. A load latches the beat-0 word; then → CAPT for a load, RESP for a store.
- CAPT latches the last word and → RESP.
- RESP asserts `rsp_valid` for exactly one cycle, then → IDLE.

**Stores**
- `mem_wdata = wdata << (8*off)` on beat 0.
- `mem_wdata = wdata >> (8*(4-off))` on beat 1.
- `mem_we = req_we` in both beats.

**Load merge**
- Take the 64-bit word `{beat1, beat0}` (beat1 = 0 when not split), shift it right by `8*off`, and take the low `size` bytes.
- LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.

**Outputs outside beats:** `mem_en`, `mem_we`, `mem_be` and `mem_wdata` are 0, and `mem_addr` holds its last value.

## Timing
- **Reset:** state IDLE; `req_ready`, `rsp_valid`, `rsp_fault`, `mem_en`, `mem_we` = 0; `mem_be`, `mem_addr`, `mem_wdata`, `rsp_rdata` = 0.
- **`req_ready` during/after reset:** low while `rst_n = 0`; high from the first cycle after release.
- **Latency** (accept at cycle T; response pulse at):
  - aligned load: T+3
  - split load: T+4
  - aligned store: T+2
  - split store: T+3
  - fault: T+1
- **Back-to-back:** the next accept is possible the cycle after RESP.
- **Reset mid-operation:** the transaction is abandoned with no response; memory outputs are 0 from the cycle after reset is sampled.
- **Input handling:** `req_*` are ignored when not accepted. `mem_rdata` is sampled only in BEAT1 (beat-0 word of a split load) and CAPT.

## Structure
- Package `lsu_pkg`:
  - the state enum;
  - a `size_of(fn3)` function;
  - a `legal(fn3, we)` function.
- `FN3_*` encodings stay in `definitions.svh`.
- One combinational sub-module, `lsu_load_align`: inputs `{beat1, beat0}`, off and fn3; output the extended word.

## Test plan
- **Aligned LW:** LW at `0x8000_2004`, memory word `0xDEAD_BEEF` → one beat with `mem_be = 4'b1111` and `mem_addr = 0x8000_2004`; `rsp_rdata = 0xDEAD_BEEF` at T+3.
- **Byte loads at lane 3:** LB at `0x8000_2013`, word `0x80xx_xxxx` → `mem_be = 4'b1000`; `rsp_rdata = 0xFFFF_FF80`. LBU at the same address → `0x0000_0080`.
- **Split LW:** LW at `0x8000_2006`, words `0x4433_2211` at `0x8000_2004` and `0x8877_6655` at `0x8000_2008`:
  - beats with `be = 1100`, then `be = 0011`;
  - `rsp_rdata = 0x6655_4433` at T+4.
- **Split SH:** SH `0x0000_ABCD` at `0x8000_200B`:
  - beat 0: `mem_addr = 0x8000_2008`, `be = 1000`, `wdata = 0xCD00_0000`;
  - beat 1: `mem_addr = 0x8000_200C`, `be = 0001`, `wdata = 0x0000_00AB`;
  - `rsp_valid` at T+3.
- **Faults:**
  - LW at `0x8000_5FFE` (crosses the window end) → `rsp_fault = 1` at T+1, no `mem_en`;
  - fn3 = 011 → fault;
  - LB at `0x8000_1FFF` → fault.
- **Reset mid-operation:** assert `rst_n = 0` during BEAT1 of a split load → no `rsp_valid`; `mem_en = 0` the next cycle; `req_ready = 1` the cycle after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
package lsu_pkg;
`include "definitions.svh"

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_CAPT,
    S_RESP
  } state_e;

  // Access width in bytes; illegal encodings are faulted before this matters.
  function automatic logic [2:0] size_of(input logic [2:0] fn3);
    case (fn3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic legal(input logic [2:0] fn3, input logic we);
    if (we) legal = fn3 inside {`FN3_SB, `FN3_SH, `FN3_SW};
    else    legal = fn3 inside {`FN3_LB, `FN3_LH, `FN3_LW, `FN3_LBU, `FN3_LHU};
  endfunction

endpackage

// File: rtl/definitions.svh
// Funct3 encodings for the load/store access types.
`ifndef LSU_DEFINITIONS_SVH
`define LSU_DEFINITIONS_SVH
`define FN3_LB  3'b000
`define FN3_LH  3'b001
`define FN3_LW  3'b010
`define FN3_LBU 3'b100
`define FN3_LHU 3'b101
`define FN3_SB  3'b000
`define FN3_SH  3'b001
`define FN3_SW  3'b010
`endif

// File: rtl/lsu_load_align.sv
// Combinational load merge: shifts the two-word window down to the access
// offset and sign- or zero-extends to 32 bits.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  fn3_i,
  output logic [31:0] rdata_o
);

  logic [31:0] sh;

  always_comb begin
    sh = 32'(data_i >> {off_i, 3'b000});
    case (fn3_i)
      `FN3_LB:  rdata_o = {{24{sh[7]}}, sh[7:0]};
      `FN3_LH:  rdata_o = {{16{sh[15]}}, sh[15:0]};
      `FN3_LBU: rdata_o = {24'd0, sh[7:0]};
      `FN3_LHU: rdata_o = {16'd0, sh[15:0]};
      default:  rdata_o = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, split into one or two
// word-aligned memory beats, with a single response pulse per request.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_2000,
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_fn3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        we_q, fault_q;
  logic [1:0]  off_q;
  logic [2:0]  fn3_q;
  logic [31:0] wdata_q, beat0_q, rdata_q, maddr_q;

  logic        accept, req_fault, split;
  logic [2:0]  req_size, size_q;
  logic [32:0] req_last, win_end;
  logic [3:0]  lane_mask;
  logic [7:0]  be_wide;
  logic [63:0] load_win;
  logic [31:0] load_word;

  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // 33-bit compare so a window ending at the top of the address space cannot wrap.
  assign req_size  = size_of(req_fn3);
  assign req_last  = {1'b0, req_addr} + {30'd0, req_size} - 33'd1;
  assign win_end   = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);
  assign req_fault = !legal(req_fn3, req_we) || (req_addr < BASE_ADDR) || (req_last >= win_end);

  assign size_q    = size_of(fn3_q);
  assign split     = ({2'b00, off_q} + {1'b0, size_q}) > 4'd4;
  assign lane_mask = (size_q == 3'd1) ? 4'b0001 : (size_q == 3'd2) ? 4'b0011 : 4'b1111;
  assign be_wide   = {4'b0000, lane_mask} << off_q;

  assign load_win  = split ? {mem_rdata, beat0_q} : {32'd0, mem_rdata};

  lsu_load_align u_align (
    .data_i  (load_win),
    .off_i   (off_q),
    .fn3_i   (fn3_q),
    .rdata_o (load_word)
  );

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    case (state_q)
      S_IDLE: if (accept) state_d = req_fault ? S_RESP : S_BEAT0;
      S_BEAT0: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = be_wide[3:0];
        mem_wdata = wdata_q << {off_q, 3'b000};
        state_d   = split ? S_BEAT1 : (we_q ? S_RESP : S_CAPT);
      end
      S_BEAT1: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = be_wide[7:4];
        mem_wdata = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
        state_d   = we_q ? S_RESP : S_CAPT;
      end
      S_CAPT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      off_q   <= 2'b00;
      fn3_q   <= 3'b000;
      wdata_q <= 32'd0;
      beat0_q <= 32'd0;
      rdata_q <= 32'd0;
      maddr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        fault_q <= req_fault;
        off_q   <= req_addr[1:0];
        fn3_q   <= req_fn3;
        wdata_q <= req_wdata;
        rdata_q <= 32'd0;
        if (!req_fault) maddr_q <= {req_addr[31:2], 2'b00};
      end
      if (state_q == S_BEAT0 && split) maddr_q <= maddr_q + 32'd4;
      if (state_q == S_BEAT1) beat0_q <= mem_rdata;
      if (state_q == S_CAPT)  rdata_q <= load_word;
    end
  end

  assign mem_addr  = maddr_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_fault = rsp_valid && fault_q;
  assign rsp_rdata = rdata_q;

endmodule
